serial_frame_rx_multi: RTL
==========================

Name: serial_frame_rx_multi

Overview:
- Parametrised successor to the single-channel serial-to-parallel DDS word reader.
- Receives key-gated serial frames from the Rabbit controller (SCLK/SDIO) in the FPGA system-clock domain.
- Routes each frame's payload to one of NUM_CH per-channel DDS holding registers using an address header, and flags short, overlong, misaddressed and stalled frames.
- Sits between the Rabbit pin inputs and the per-DDS programming blocks.

Parameters:
- FRAME_BITS, 184, payload bits per frame.
- NUM_CH, 2, number of destination channels (DDS devices).
- ADDR_BITS, 1, header bits preceding the payload; ADDR_BITS ≥ 1 and 2^ADDR_BITS ≥ NUM_CH.
- TIMEOUT_CLKS, 4096, number of clk cycles without an SCLK rising edge mid-frame before the frame aborts.

Ports:
- clk  in  1  system clock; all logic is synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- sclk_in  in  1  Rabbit serial clock (asynchronous to clk).
- sdio_in  in  1  Rabbit serial data; sampled on the sclk_in rising edge.
- init_key_flag  in  1  frame gate (asynchronous to clk); low = frame active.
- data_out  out  NUM_CH*FRAME_BITS  channel c occupies bits [(c+1)*FRAME_BITS-1 : c*FRAME_BITS].
- ch_valid  out  NUM_CH  one-cycle pulse per channel when its data_out slice updates.
- frame_err  out  1  one-cycle pulse on any aborted or rejected frame.
- overrun  out  1  sticky; cleared at the start of the next frame.
- busy  out  1  high while in SHIFT.

Behaviour:
- Input synchronisation:
  - sclk_in, sdio_in and init_key_flag each pass through a 2-FF synchroniser.
  - The SCLK rising edge is detected as sync = 1 with the previous sync value = 0 (sclk_rise).
  - The sdio value is taken from the same synchronised stage as the sclk edge.
- Bit ordering:
  - The first ADDR_BITS received bits form the address, MSB first.
  - The next FRAME_BITS bits form the payload; the first payload bit lands in the payload MSB.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: the counter is cleared. A synchronised key falling edge (1→0) moves to SHIFT and clears overrun. SCLK edges in IDLE are ignored.
  - SHIFT: each sclk_rise shifts in one bit and increments the counter (width clog2(ADDR_BITS+FRAME_BITS+1)).
  - SHIFT, frame complete: when the counter reaches ADDR_BITS+FRAME_BITS, go to HOLD the cycle after the final sclk_rise.
    - If address < NUM_CH: that channel's data_out slice loads the payload and its ch_valid bit pulses for 1 clk.
    - Otherwise: frame_err pulses and data_out is unchanged.
  - SHIFT, key rises before complete: abort, frame_err pulses, go to IDLE, data_out unchanged.
  - SHIFT, timeout: TIMEOUT_CLKS consecutive clks with no sclk_rise abort the frame (frame_err, go to IDLE). The timeout counter resets on every sclk_rise.
  - HOLD: any sclk_rise sets overrun; the bits are discarded. Key rising moves to IDLE. No timeout in HOLD.
- Latency:
  - ch_valid is asserted 4 clks after the raw sclk_in rising edge that carries the last bit (2 sync + 1 edge detect + 1 register).
  - data_out and ch_valid update in the same cycle.
- Simultaneous events:
  - Final sclk_rise and key rise in the same clk: the frame completes normally (counter check has priority), then the FSM passes HOLD→IDLE.
  - Key falling again while in HOLD without a rise between: ignored.
- Reset (asynchronous, any time including mid-frame):
  - state IDLE, counters 0, data_out all 0, ch_valid 0, frame_err 0, overrun 0, busy 0.
  - A partial frame is discarded; a new frame needs a fresh key falling edge after reset_n deasserts.
- Unaddressed channels hold their data_out indefinitely.

Test Plan:
- Reset then key low, 185 clocks (addr = 1, payload = 184'h1 pattern MSB-first), key high → ch_valid = 2'b10 for one clk, data_out[367:184] = 184'h1, data_out[183:0] = 0, frame_err = 0.
- Two back-to-back frames: addr 0 payload all-ones, then addr 1 payload alternating 1010… → both slices correct, exactly two single-cycle ch_valid pulses, no frame_err.
- Key rises after 100 SCLKs → frame_err pulses once, data_out unchanged, busy falls, next full frame accepted.
- 190 SCLKs within one key-low window → frame accepted at bit 185, overrun = 1 until the next key fall, data_out reflects only the first 185 bits.
- SCLK stops after 50 bits with key held low for > 4096 clks → frame_err at timeout, state IDLE. Further SCLKs without a new key fall → no ch_valid.
- NUM_CH = 3, ADDR_BITS = 2, address 3 → frame_err, no ch_valid. Also assert reset_n mid-frame at bit 90 → all outputs 0 immediately.

Source files
------------

// File: rtl/serial_frame_rx_multi.sv
// Key-gated serial frame receiver: synchronises Rabbit SCLK/SDIO/key into clk,
// decodes an address header and loads the payload into one of NUM_CH holding registers.
module serial_frame_rx_multi #(
   parameter int unsigned FRAME_BITS   = 184,
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned ADDR_BITS    = 1,
   parameter int unsigned TIMEOUT_CLKS = 4096
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         sclk_in,
   input  logic                         sdio_in,
   input  logic                         init_key_flag,
   output logic [NUM_CH*FRAME_BITS-1:0] data_out,
   output logic [NUM_CH-1:0]            ch_valid,
   output logic                         frame_err,
   output logic                         overrun,
   output logic                         busy
);

   localparam int unsigned TOTAL_BITS = ADDR_BITS + FRAME_BITS;
   localparam int unsigned CNT_W      = $clog2(TOTAL_BITS + 1);
   localparam int unsigned TO_W       = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

   state_t                         r_state;
   logic                           r_sclk_meta, r_sclk_sync, r_sclk_prev;
   logic                           r_sdio_meta, r_sdio_sync;
   logic                           r_key_meta, r_key_sync, r_key_prev;
   logic [CNT_W-1:0]               r_cnt;
   logic [TO_W-1:0]                r_to_cnt;
   logic [TOTAL_BITS-1:0]          r_shift;
   logic [NUM_CH*FRAME_BITS-1:0]   r_data;
   logic [NUM_CH-1:0]              r_ch_valid;
   logic                           r_frame_err;
   logic                           r_overrun;
   logic                           r_busy;

   logic                           w_sclk_rise;
   logic                           w_key_fall;
   logic [ADDR_BITS-1:0]           w_addr;
   logic [FRAME_BITS-1:0]          w_payload;
   logic [NUM_CH-1:0]              w_hit;

   // Key sync resets low so a key already held low across reset is not seen as a new frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sclk_meta <= 1'b0;
         r_sclk_sync <= 1'b0;
         r_sclk_prev <= 1'b0;
         r_sdio_meta <= 1'b0;
         r_sdio_sync <= 1'b0;
         r_key_meta  <= 1'b0;
         r_key_sync  <= 1'b0;
         r_key_prev  <= 1'b0;
      end else begin
         r_sclk_meta <= sclk_in;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_prev <= r_sclk_sync;
         r_sdio_meta <= sdio_in;
         r_sdio_sync <= r_sdio_meta;
         r_key_meta  <= init_key_flag;
         r_key_sync  <= r_key_meta;
         r_key_prev  <= r_key_sync;
      end
   end

   assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
   assign w_key_fall  = ~r_key_sync & r_key_prev;
   assign w_addr      = r_shift[TOTAL_BITS-1 -: ADDR_BITS];
   assign w_payload   = r_shift[FRAME_BITS-1:0];

   always_comb begin
      w_hit = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_hit[c] = (w_addr == ADDR_BITS'(c));
      end
   end

   // Frame FSM; completion is checked before key/timeout so a last bit coincident with key rise still lands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_to_cnt    <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_ch_valid  <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_ch_valid  <= '0;
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_key_fall) begin
                  r_state   <= S_SHIFT;
                  r_busy    <= 1'b1;
                  r_overrun <= 1'b0;
                  r_to_cnt  <= '0;
               end
            end
            S_SHIFT: begin
               if (r_cnt == CNT_W'(TOTAL_BITS)) begin
                  r_state <= S_HOLD;
                  r_busy  <= 1'b0;
                  if (w_sclk_rise) r_overrun <= 1'b1;
                  if (|w_hit) begin
                     r_ch_valid <= w_hit;
                     for (int c = 0; c < NUM_CH; c++) begin
                        if (w_hit[c]) r_data[c*FRAME_BITS +: FRAME_BITS] <= w_payload;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else if (w_sclk_rise) begin
                  r_shift  <= {r_shift[TOTAL_BITS-2:0], r_sdio_sync};
                  r_cnt    <= r_cnt + CNT_W'(1);
                  r_to_cnt <= '0;
               end else if (r_key_sync || (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1))) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_frame_err <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            S_HOLD: begin
               if (w_sclk_rise) r_overrun <= 1'b1;
               if (r_key_sync)  r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = r_data;
   assign ch_valid  = r_ch_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = r_busy;

endmodule
